cdb_arbiter: RTL
================

# cdb_arbiter

Arbitrates the single common data bus (CDB) between the two result producers, the ALU and the load/store buffer, and broadcasts one `(rob_id, value)` result per cycle to the reservation station, the load/store buffer and the ROB. Each producer feeds a small per-source queue. A round-robin grant picks between the queues when both are non-empty. This guarantees each producer is served within one cycle of the other, and turns two result ports into one registered broadcast.

## Interface
Parameters:
- `ROB_BITS`, default `` `robsize `` (4): ROB tag width.
- `Q_DEPTH`, default 2: entries per source queue; power of two, ≥2.

Ports (`clk`, `rst`: one clock; reset is asynchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `rdy` input 1: global enable; low freezes all state.
- `flush` input 1: misprediction clear, synchronous.
- `alu_valid` input 1: ALU result present.
- `alu_rob_id` input ROB_BITS: ALU result tag.
- `alu_value` input 32: ALU result value.
- `alu_stall` output 1: ALU queue full; the ALU must hold its result.
- `lsb_valid` input 1: LSB result present.
- `lsb_rob_id` input ROB_BITS: LSB result tag.
- `lsb_value` input 32: LSB result value.
- `lsb_stall` output 1: LSB queue full.
- `cdb_valid` output 1: broadcast valid, registered.
- `cdb_rob_id` output ROB_BITS: broadcast tag, registered.
- `cdb_value` output 32: broadcast value, registered.
- `cdb_src` output 1: 0 = ALU, 1 = LSB, registered.

## Operation
- Each source has its own FIFO with a `Q_DEPTH+1`-bit count.
- `x_stall = (count_x == Q_DEPTH)`. This is combinational from registered count only, with no dependence on inputs.
- Enqueue when `rdy && x_valid && !x_stall && !flush`.
  - `x_valid` while stalled is ignored. Holding the result is the producer's responsibility.
  - No enqueue into a full queue, even if the same queue dequeues that cycle.
- Grant each `rdy` cycle, evaluated on the registered queue state:
  - Only one queue non-empty: grant it.
  - Both non-empty: grant the source opposite `last_grant`, then set `last_grant` to the granted source.
  - Neither non-empty: no grant; `cdb_valid <= 0`.
- On a grant, the head entry is popped and loaded into the `cdb_*` registers with `cdb_valid <= 1`.
- A queue may enqueue and dequeue in the same cycle; its count is unchanged.
- `flush` (with `rdy`) empties both queues, clears `cdb_valid`, and discards same-cycle inputs. `last_grant` is kept.
- `rdy` low: no enqueue, no dequeue, and the `cdb_*` registers hold their values.

## Timing
- Reset values:
  - `cdb_valid`=0, `cdb_rob_id`=0, `cdb_value`=0, `cdb_src`=0.
  - Both counts 0, so `alu_stall`=`lsb_stall`=0.
  - Read/write pointers 0.
  - `last_grant`=1, so the ALU wins the first tie.
- Latency: a result enqueued at edge N into an empty queue with no contention appears on `cdb_*` after edge N+1. There is no same-cycle bypass.
- Throughput: one broadcast per cycle. Under sustained contention, sources alternate strictly.
- Queue order is FIFO per source; there is no ordering between sources.
- Pointer wrap: modulo `Q_DEPTH`; the count distinguishes full from empty.
- Reset mid-operation: immediate clear regardless of `clk`/`rdy`; any in-flight results are lost.

## Structure
- The ROB tag width comes from the shared `const.v` (`` `robsize ``).
- Add `` `cdb_src_alu `` = 0 and `` `cdb_src_lsb `` = 1 to `const.v`.
- Sub-module `cdb_queue`: parameterised FIFO with `push`, `pop`, `flush`, `head`, `count`, and asynchronous reset. It is instantiated twice.
- The arbiter's top level holds only the grant logic, `last_grant`, and the output registers.

## Test plan
- Reset, idle: `cdb_valid`=0, stalls=0. ALU `(3, 0x11)` at edge 1 → `cdb` = `(3, 0x11, src 0)` after edge 2; `cdb_valid`=0 after edge 3.
- Simultaneous: ALU `(1, 0xA)` and LSB `(2, 0xB)` at edge 1 → broadcast ALU after edge 2, then LSB after edge 3.
- Sustained contention: both sources push every non-stalled cycle for 8 cycles → `cdb_src` alternates 0,1,0,1…. Stalls assert when a count reaches 2, and no tag is lost or duplicated.
- Full queue: LSB pushes tags 4, 5, 6 on consecutive cycles while the ALU floods.
  - `lsb_stall`=1 while full; tag 6 is accepted only once the stall drops.
  - Output order of LSB tags is 4, 5, 6.
- Flush and `rdy`:
  - With both queues holding 2 entries, `flush` → counts 0, `cdb_valid`=0 next cycle, same-cycle input dropped.
  - `rdy`=0 for 3 cycles mid-stream → `cdb_*` frozen and queues unchanged.
- Asynchronous reset asserted between edges while `cdb_valid`=1 → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared ROB tag width and CDB source encoding for the arbiter slice.
package cdb_arbiter_pkg;
    localparam int ROB_SIZE = 4;
    typedef enum logic {CDB_SRC_ALU = 1'b0, CDB_SRC_LSB = 1'b1} cdb_src_e;
endpackage

// File: rtl/cdb_queue.sv
// cdb_queue: small power-of-two FIFO holding pending results for one CDB producer.
module cdb_queue #(
    parameter int W = 36,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PB = $clog2(DEPTH);
    localparam int CW = PB + 1;
    logic [W-1:0] mem [DEPTH];
    logic [PB-1:0] wp, rp;
    assign head = mem[rp];
    // Pointers wrap naturally at DEPTH; count tells full from empty.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push && !flush) mem[wp] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of ALU and LSB results onto one registered CDB broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_BITS = ROB_SIZE,
    parameter int Q_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [ROB_BITS-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    output logic                alu_stall,
    input  logic                lsb_valid,
    input  logic [ROB_BITS-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                lsb_stall,
    output logic                cdb_valid,
    output logic [ROB_BITS-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src
);
    localparam int W = ROB_BITS + 32;
    localparam int CW = $clog2(Q_DEPTH) + 1;
    logic [CW-1:0] alu_count, lsb_count;
    logic [W-1:0] alu_head, lsb_head;
    logic alu_ne, lsb_ne, gnt_lsb, grant, alu_push, lsb_push, alu_pop, lsb_pop, qflush;
    cdb_src_e last_grant;
    always_comb begin
        alu_stall = alu_count == CW'(Q_DEPTH);
        lsb_stall = lsb_count == CW'(Q_DEPTH);
        alu_ne = alu_count != '0;
        lsb_ne = lsb_count != '0;
        gnt_lsb = lsb_ne && (!alu_ne || last_grant == CDB_SRC_ALU);
        grant = alu_ne || lsb_ne;
        qflush = rdy && flush;
        alu_push = rdy && !flush && alu_valid && !alu_stall;
        lsb_push = rdy && !flush && lsb_valid && !lsb_stall;
        alu_pop = rdy && !flush && alu_ne && !gnt_lsb;
        lsb_pop = rdy && !flush && gnt_lsb;
    end
    cdb_queue #(.W(W), .DEPTH(Q_DEPTH)) u_alu_q (
        .clk(clk), .rst(rst), .push(alu_push), .pop(alu_pop), .flush(qflush),
        .din({alu_rob_id, alu_value}), .head(alu_head), .count(alu_count)
    );
    cdb_queue #(.W(W), .DEPTH(Q_DEPTH)) u_lsb_q (
        .clk(clk), .rst(rst), .push(lsb_push), .pop(lsb_pop), .flush(qflush),
        .din({lsb_rob_id, lsb_value}), .head(lsb_head), .count(lsb_count)
    );
    // last_grant only moves on a tie, so a lone source does not steal the next tie.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value <= '0;
            cdb_src <= CDB_SRC_ALU;
            last_grant <= CDB_SRC_LSB;
        end else if (rdy) begin
            cdb_valid <= grant && !flush;
            if (grant && !flush) begin
                {cdb_rob_id, cdb_value} <= gnt_lsb ? lsb_head : alu_head;
                cdb_src <= gnt_lsb;
                if (alu_ne && lsb_ne) last_grant <= gnt_lsb ? CDB_SRC_LSB : CDB_SRC_ALU;
            end
        end
endmodule
